entrada_debounce_ctrl: RTL and testbench
========================================

ENTRADA_DEBOUNCE_CTRL -- requirements
Module: entrada_debounce_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 50000: consecutive stable synchronized samples needed to accept a button press or release; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports btnU, btnD, btnL, btnR, btnC, input, 1 each: raw, asynchronous, bouncing push-buttons, active-high.
REQ-005 SHALL have port sw, input, 16: operand switches; sw[7:0] feeds A, sw[15:8] feeds B.
REQ-006 SHALL have port A, output, 8: registered operand A.
REQ-007 SHALL have port B, output, 8: registered operand B.
REQ-008 SHALL have port ALUControl, output, 3: registered operation select for the downstream ALU.
REQ-009 SHALL have port Cantidad, output, 2: registered shift/rotate amount for the downstream ALU.
REQ-010 SHALL have port load_pulse, output, 1: one-cycle strobe, high in the cycle A/B take new values.

Function
REQ-011 SHALL pass each button through a 2-flop synchronizer; no raw button reaches any other logic.
REQ-012 SHALL give each button its own 4-state debounce FSM: IDLE (released), WAIT_PRESS, PRESSED, WAIT_RELEASE.
REQ-013 IDLE -> WAIT_PRESS when synchronized sample = 1; counter cleared to 0.
REQ-014 WAIT_PRESS: counter increments each cycle sample = 1; sample = 0 -> back to IDLE, counter cleared; counter reaching DEB_CYCLES-1 with sample = 1 -> PRESSED.
REQ-015 PRESSED -> WAIT_RELEASE when sample = 0; WAIT_RELEASE mirrors WAIT_PRESS with polarity inverted (sample = 1 -> back to PRESSED; DEB_CYCLES stable 0 samples -> IDLE).
REQ-016 SHALL generate a one-cycle press event on each WAIT_PRESS -> PRESSED transition only; release generates no event; a held button generates exactly one event.
REQ-017 Total latency: a press event SHALL be visible on outputs exactly DEB_CYCLES+3 rising clk edges after the first edge that samples the raw button high, assuming no bounce.
REQ-018 btnU event: ALUControl <= ALUControl+1, modulo 8 (7 -> 0).
REQ-019 btnD event: ALUControl <= ALUControl-1, modulo 8 (0 -> 7).
REQ-020 btnR event: Cantidad <= Cantidad+1, modulo 4 (3 -> 0).
REQ-021 btnL event: Cantidad <= Cantidad-1, modulo 4 (0 -> 3).
REQ-022 btnU and btnD events in the same cycle: ALUControl unchanged; likewise btnL and btnR for Cantidad.
REQ-023 btnC event: A <= sw[7:0], B <= sw[15:8], load_pulse = 1 for exactly that cycle; sw changes at any other time SHALL NOT affect A/B.
REQ-024 Events on different control groups (U/D, L/R, C) in the same cycle SHALL all take effect independently.
REQ-025 Counter width SHALL be 16 bits; counter SHALL never wrap.
REQ-026 All outputs SHALL be driven directly from flops (no combinational path from inputs to outputs).

Reset
REQ-027 rst_n = 0 SHALL asynchronously force A = 0x00, B = 0x00, ALUControl = 3'b000, Cantidad = 2'b00, load_pulse = 0, all FSMs to IDLE, all counters and synchronizer flops to 0.
REQ-028 Reset asserted mid-debounce SHALL discard the pending press; after release, a button still held SHALL need a full fresh DEB_CYCLES qualification, producing one event.
REQ-029 Deassertion of rst_n SHALL be sampled on clk; first possible event no earlier than DEB_CYCLES+3 edges after deassertion.

Verification (DEB_CYCLES = 4)
REQ-030 Clean btnU press held 20 cycles -> ALUControl 0 -> 1 exactly 7 edges after first sampled high, one change only.
REQ-031 btnD pressed from reset -> ALUControl = 7; btnL pressed from reset -> Cantidad = 3 (wrap-down).
REQ-032 btnR bouncing 1,0,1,1,0 then stable high 10 cycles -> Cantidad 0 -> 1, exactly one increment.
REQ-033 sw = 0xA55A, btnC press -> A = 0x5A, B = 0xA5, load_pulse high one cycle; then sw = 0xFFFF, no press -> A/B unchanged.
REQ-034 btnU and btnD asserted on the same edge and held -> ALUControl unchanged; simultaneous btnC still loads A/B.
REQ-035 rst_n pulsed low at cycle 3 of a btnU debounce, button still held -> all outputs 0 immediately, then ALUControl = 1 exactly DEB_CYCLES+3 edges after release of reset.

Source files
------------

// File: rtl/entrada_debounce_ctrl.sv
// entrada_debounce_ctrl: debounced push-button control of ALU operands, operation select and shift amount
module entrada_debounce_btn #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic ev
);
  typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} state_t;
  localparam logic [15:0] LAST = 16'(DEB_CYCLES - 2);
  state_t st;
  logic [1:0] sync;
  logic [15:0] cnt;
  logic s;
  assign s = sync[1];
  // cnt==LAST on a qualifying sample means DEB_CYCLES stable samples including the entry one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      sync <= '0;
      cnt <= '0;
      ev <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      ev <= 1'b0;
      case (st)
        IDLE: if (s) begin
          st <= WAIT_PRESS;
          cnt <= '0;
        end
        WAIT_PRESS: if (!s) begin
          st <= IDLE;
          cnt <= '0;
        end else if (cnt == LAST) begin
          st <= PRESSED;
          ev <= 1'b1;
          cnt <= '0;
        end else cnt <= cnt + 16'd1;
        PRESSED: if (!s) begin
          st <= WAIT_RELEASE;
          cnt <= '0;
        end
        WAIT_RELEASE: if (s) begin
          st <= PRESSED;
          cnt <= '0;
        end else if (cnt == LAST) begin
          st <= IDLE;
          cnt <= '0;
        end else cnt <= cnt + 16'd1;
        default: st <= IDLE;
      endcase
    end
endmodule

module entrada_debounce_ctrl #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btnU,
  input  logic        btnD,
  input  logic        btnL,
  input  logic        btnR,
  input  logic        btnC,
  input  logic [15:0] sw,
  output logic [7:0]  A,
  output logic [7:0]  B,
  output logic [2:0]  ALUControl,
  output logic [1:0]  Cantidad,
  output logic        load_pulse
);
  logic [4:0] raw, ev;
  assign raw = {btnC, btnR, btnL, btnD, btnU};
  genvar i;
  for (i = 0; i < 5; i++) begin : g_btn
    entrada_debounce_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
      .clk(clk), .rst_n(rst_n), .raw(raw[i]), .ev(ev[i])
    );
  end
  // opposing events in the same cycle cancel; groups update independently
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      A <= '0;
      B <= '0;
      ALUControl <= '0;
      Cantidad <= '0;
      load_pulse <= 1'b0;
    end else begin
      ALUControl <= ALUControl + 3'(ev[0] & ~ev[1]) - 3'(ev[1] & ~ev[0]);
      Cantidad <= Cantidad + 2'(ev[3] & ~ev[2]) - 2'(ev[2] & ~ev[3]);
      load_pulse <= ev[4];
      if (ev[4]) begin
        A <= sw[7:0];
        B <= sw[15:8];
      end
    end
endmodule

// File: tb/tb_entrada_debounce_ctrl.sv
// tb_entrada_debounce_ctrl: scoreboard bench; expected output changes queued with their exact cycle
module tb_entrada_debounce_ctrl;
  localparam int D = 4;
  logic clk = 1'b0, rst_n = 1'b1;
  logic btnU = 0, btnD = 0, btnL = 0, btnR = 0, btnC = 0;
  logic [15:0] sw = '0;
  logic [7:0] A, B;
  logic [2:0] ALUControl;
  logic [1:0] Cantidad;
  logic load_pulse;
  logic [21:0] obs;
  int cyc = 0;
  int passed = 0, total = 0;
  typedef struct {logic [21:0] v; int c;} exp_t;
  exp_t q[$];

  entrada_debounce_ctrl #(.DEB_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
    .btnC(btnC), .sw(sw), .A(A), .B(B), .ALUControl(ALUControl), .Cantidad(Cantidad),
    .load_pulse(load_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign obs = {A, B, ALUControl, Cantidad, load_pulse};

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", n, got, exp, cyc);
  endtask

  task automatic expect_at(input int c, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] al, input logic [1:0] ca, input logic lp);
    exp_t e;
    e.v = {a, b, al, ca, lp};
    e.c = c;
    q.push_back(e);
  endtask

  task automatic press(input logic u, input logic d, input logic l, input logic r,
                       input logic c, input int hold);
    {btnU, btnD, btnL, btnR, btnC} = {u, d, l, r, c};
    repeat (hold) @(negedge clk);
    {btnU, btnD, btnL, btnR, btnC} = '0;
    repeat (D + 8) @(negedge clk);
  endtask

  // monitor: every change of the output tuple must match the head of the queue at its cycle
  initial begin
    logic [21:0] prev;
    exp_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (obs !== prev) begin
        if (q.size() == 0) chk("unexpected_change", 32'(obs), 32'(prev));
        else begin
          e = q.pop_front();
          chk("out_value", 32'(obs), 32'(e.v));
          if (e.c >= 0) chk("out_cycle", cyc, e.c);
        end
        prev = obs;
      end else if (q.size() > 0 && q[0].c >= 0 && cyc > q[0].c) begin
        e = q.pop_front();
        chk("out_late", 32'(obs), 32'(e.v));
      end
    end
  end

  initial begin
    logic [4:0] pat;
    #2 rst_n = 1'b0;
    #1 chk("reset_state", 32'(obs), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_at(cyc + D + 3, 8'h00, 8'h00, 3'd1, 2'd0, 1'b0);
    press(1, 0, 0, 0, 0, 20);
    expect_at(cyc + D + 3, 8'h00, 8'h00, 3'd0, 2'd0, 1'b0);
    press(0, 1, 0, 0, 0, 10);
    expect_at(cyc + D + 3, 8'h00, 8'h00, 3'd7, 2'd0, 1'b0);
    press(0, 1, 0, 0, 0, 10);
    expect_at(cyc + D + 3, 8'h00, 8'h00, 3'd0, 2'd0, 1'b0);
    press(1, 0, 0, 0, 0, 10);
    expect_at(cyc + D + 3, 8'h00, 8'h00, 3'd0, 2'd3, 1'b0);
    press(0, 0, 1, 0, 0, 10);
    pat = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      btnR = pat[i];
      @(negedge clk);
    end
    expect_at(cyc + D + 3, 8'h00, 8'h00, 3'd0, 2'd0, 1'b0);
    press(0, 0, 0, 1, 0, 10);
    expect_at(cyc + D + 3, 8'h00, 8'h00, 3'd0, 2'd1, 1'b0);
    press(0, 0, 0, 1, 0, 10);
    sw = 16'hA55A;
    expect_at(cyc + D + 3, 8'h5A, 8'hA5, 3'd0, 2'd1, 1'b1);
    expect_at(cyc + D + 4, 8'h5A, 8'hA5, 3'd0, 2'd1, 1'b0);
    press(0, 0, 0, 0, 1, 10);
    sw = 16'hFFFF;
    repeat (20) @(negedge clk);
    chk("ab_hold", 32'({A, B}), 32'h5AA5);
    sw = 16'h1234;
    expect_at(cyc + D + 3, 8'h34, 8'h12, 3'd0, 2'd1, 1'b1);
    expect_at(cyc + D + 4, 8'h34, 8'h12, 3'd0, 2'd1, 1'b0);
    press(1, 1, 0, 0, 1, 12);
    expect_at(cyc + D + 3, 8'h34, 8'h12, 3'd1, 2'd2, 1'b0);
    press(1, 0, 0, 1, 0, 12);
    btnU = 1'b1;
    repeat (3) @(negedge clk);
    expect_at(-1, 8'h00, 8'h00, 3'd0, 2'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("reset_async", 32'(obs), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_at(cyc + D + 3, 8'h00, 8'h00, 3'd1, 2'd0, 1'b0);
    repeat (20) @(negedge clk);
    btnU = 1'b0;
    repeat (D + 8) @(negedge clk);
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    chk("queue_drain", q.size(), 0);
    chk("final_state", 32'(obs), 32'({8'h00, 8'h00, 3'd1, 2'd0, 1'b0}));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
